ahbl_slave_mem: RTL

AHBL_SLAVE_MEM -- requirements
Module: ahbl_slave_mem

---
 rtl/ahbl_pkg.sv | 41 ++++
 rtl/ahbl_slave_mem_if.sv | 26 ++
 rtl/ahbl_slave_ram.sv | 29 ++
 rtl/ahbl_slave_mem.sv | 112 +++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helpers.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian lane mask for a transfer of the given size at byte offset addr.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << addr;
      HSIZE_HALF: byte_lanes = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic xfer_aligned(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: xfer_aligned = 1'b1;
      HSIZE_HALF: xfer_aligned = ~addr[0];
      HSIZE_WORD: xfer_aligned = (addr == 2'b00);
      default:    xfer_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_slave_mem_if.sv
// AHB-Lite slave-side bus bundle; HREADY is the interconnect's combined ready.
interface ahbl_slave_mem_if;
  import ahbl_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahbl_slave_ram.sv
// MEM_WORDS x 32 storage: combinational read, synchronous byte-enabled write.
// Reset reloads every word with INIT_VALUE and takes priority over a write.
module ahbl_slave_ram #(
  parameter int          MEM_WORDS  = 256,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [3:0]                   i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite memory slave: optional wait states, two-cycle ERROR response for
// illegal transfers, writes committed on the final data-phase cycle.
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
  input logic             HCLK,
  input logic             HRESET,
  ahbl_slave_mem_if.slave bus
);

  localparam int         AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [AW+1:0] r_addr;
  logic          r_write;
  logic [2:0]    r_size;
  logic          r_dphase;
  logic          w_accept;
  logic          w_legal;
  logic          w_final;
  logic [3:0]    w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^bus.HBURST;

  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_legal  = xfer_aligned(bus.HSIZE, bus.HADDR[1:0]) &&
                    (bus.HADDR < 32'(MEM_WORDS * 4));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= 3'd0;
      r_dphase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Address-phase fields only move when the bus advances.
      if (bus.HREADY) begin
        r_dphase <= w_accept & w_legal;
        if (w_accept) begin
          r_addr  <= bus.HADDR[AW+1:0];
          r_write <= bus.HWRITE;
          r_size  <= bus.HSIZE;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == WS) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The last data-phase cycle of a legal transfer is always spent in IDLE.
  assign w_final = (r_state == ST_IDLE) & r_dphase;
  assign w_we    = (w_final & r_write & ~HRESET) ? byte_lanes(r_size, r_addr[1:0]) : 4'b0000;

  assign bus.HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign bus.HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (w_final & ~r_write) ? w_rdata : 32'h0000_0000;

  // A read right after a write lands after the write's commit edge, so the
  // combinational RAM read already returns the byte-merged word.
  ahbl_slave_ram #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_VALUE(INIT_VALUE)
  ) u_ram (
    .i_clk  (HCLK),
    .i_rst  (HRESET),
    .i_we   (w_we),
    .i_addr (r_addr[AW+1:2]),
    .i_wdata(bus.HWDATA),
    .o_rdata(w_rdata)
  );

endmodule
